// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  // A fault is a misaligned byte address or an address beyond the RAM span.
  function automatic logic is_fault(input logic [WORD_W-1:0] addr, input int depth_log2);
    logic [WORD_W-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM; read and write share one edge, read returns the old word.
module dmem_sp_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = WORD_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DEPTH_LOG2-1:0] raddr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

  // Storage array and registered read port (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    dout <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches a request, waits LATENCY cycles, then completes it
// with a one-cycle ready (and err on a faulting address).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] addr,
  input  logic              write,
  input  logic              mreq,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data,
  output logic              ready,
  output logic              err
);

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WORD_W-1:0]     addr_q, wdata_q, rd_hold_q;
  logic                  op_wr_q;

  logic [WORD_W-1:0]     eff_addr, eff_wdata, ram_dout;
  logic                  eff_wr, eff_fault, ram_we;
  logic [DEPTH_LOG2-1:0] eff_word;

  // The RAM access happens on the edge into DONE. With LATENCY=0 that edge is the
  // sampling edge itself, so the live bus is used in IDLE and the latched copy otherwise.
  always_comb begin
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    eff_wr    = op_wr_q;
    if (state_q == IDLE) begin
      eff_addr  = addr;
      eff_wdata = wr_data;
      eff_wr    = write;
    end
    eff_word  = eff_addr[DEPTH_LOG2+1:2];
    eff_fault = is_fault(eff_addr, DEPTH_LOG2);
    ram_we    = (state_d == DONE) && eff_wr && !eff_fault;
  end

  dmem_sp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(eff_word),
    .raddr(eff_word),
    .din  (eff_wdata),
    .dout (ram_dout)
  );

  // Next-state, wait counter and completion outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    err     = 1'b0;
    rd_data = rd_hold_q;
    case (state_q)
      IDLE: begin
        if (mreq || write) begin
          cnt_d   = LAT_CNT;
          state_d = (LATENCY == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ready   = 1'b1;
        err     = is_fault(addr_q, DEPTH_LOG2);
        if (!op_wr_q) rd_data = err ? '0 : ram_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, latched request and read-data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_hold_q <= rd_data;
      if (state_q == IDLE && (mreq || write)) begin
        addr_q  <= addr;
        wdata_q <= wr_data;
        op_wr_q <= write;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_data_mem_responder;

  localparam int DL2 = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic        a_write, a_mreq, a_ready, a_err;
  logic [31:0] b_addr, b_wdata, b_rd;
  logic        b_write, b_mreq, b_ready, b_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .addr(a_addr), .write(a_write), .mreq(a_mreq),
    .wr_data(a_wdata), .rd_data(a_rd), .ready(a_ready), .err(a_err)
  );

  data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(b_addr), .write(b_write), .mreq(b_mreq),
    .wr_data(b_wdata), .rd_data(b_rd), .ready(b_ready), .err(b_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a sparse word memory plus the last returned read value.
  logic [31:0] mem_m [int unsigned];
  logic [31:0] rd_m;

  function automatic bit ref_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd4 << DL2));
  endfunction

  // One transaction on the LATENCY=2 instance; the bus is scrambled while waiting.
  task automatic txn(input string tag, input bit w, input bit r,
                     input logic [31:0] a, input logic [31:0] d);
    int n;
    bit got;
    bit f;
    @(negedge clk);
    a_addr = a; a_write = w; a_mreq = r; a_wdata = d;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (a_ready) got = 1;
      else begin
        a_addr  = $urandom;
        a_wdata = $urandom;
      end
    end
    a_write = 1'b0; a_mreq = 1'b0;
    f = ref_fault(a);
    if (w) begin
      if (!f) mem_m[a >> 2] = d;
    end else begin
      rd_m = f ? 32'h0 : (mem_m.exists(a >> 2) ? mem_m[a >> 2] : 32'hX);
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT + 1));
    chk({tag, "_err"}, {31'b0, a_err}, {31'b0, f});
    chk({tag, "_rd"}, a_rd, rd_m);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, a_ready}, 32'h0);
    chk({tag, "_hold"}, a_rd, rd_m);
  endtask

  initial begin
    int pulses;
    bit prev;
    logic [31:0] a, d;
    rd_m = 32'h0;
    rst_n = 1'b0;
    a_addr = '0; a_write = 0; a_mreq = 0; a_wdata = '0;
    b_addr = '0; b_write = 0; b_mreq = 0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, a_ready}, 32'h0);
    chk("rst_err", {31'b0, a_err}, 32'h0);
    chk("rst_rd", a_rd, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, a_ready}, 32'h0);

    // Reset during WAIT aborts a pending write.
    txn("pre_w40", 1, 0, 32'h40, 32'h11111111);
    @(negedge clk);
    a_addr = 32'h40; a_write = 1; a_wdata = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait_ready", {31'b0, a_ready}, 32'h0);
    rst_n = 1'b0; a_write = 0;
    rd_m = 32'h0;
    @(negedge clk);
    chk("abort_rst_ready", {31'b0, a_ready}, 32'h0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_ready) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'h0);
    txn("abort_rb", 0, 1, 32'h40, 32'h0);

    // Directed cases.
    txn("w10", 1, 0, 32'h10, 32'hDEADBEEF);
    txn("r10", 0, 1, 32'h10, 32'h0);
    txn("w0", 1, 0, 32'h0, 32'h0BADF00D);
    txn("r_mis", 0, 1, 32'h12, 32'h0);
    txn("w_oor", 1, 0, 32'h1000, 32'hFFFFFFFF);
    txn("r0", 0, 1, 32'h0, 32'h0);
    txn("both20", 1, 1, 32'h20, 32'h12345678);
    txn("r20", 0, 1, 32'h20, 32'h0);
    txn("w4", 1, 0, 32'h4, 32'hA5A5A5A5);
    txn("w8", 1, 0, 32'h8, 32'h5A5A5A5A);
    txn("r4", 0, 1, 32'h4, 32'h0);
    txn("r8", 0, 1, 32'h8, 32'h0);

    // Random traffic: seed a small window, then mix reads, writes and faults.
    for (int i = 0; i < 16; i++) txn("seed", 1, 0, 32'(i * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
        1: a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      d = $urandom;
      if ($urandom_range(0, 1) == 1) txn("rnd_w", 1, $urandom_range(0, 1) == 1, a, d);
      else txn("rnd_r", 0, 1, a, d);
    end

    // LATENCY=0: held read alternates IDLE/DONE, one pulse every second cycle.
    @(negedge clk);
    b_addr = 32'h0; b_write = 1; b_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("l0_w_ready", {31'b0, b_ready}, 32'h1);
    chk("l0_w_err", {31'b0, b_err}, 32'h0);
    b_write = 0;
    @(negedge clk);
    b_mreq = 1;
    pulses = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("l0_no_back2back", {31'b0, prev & b_ready}, 32'h0);
      if (b_ready) begin
        pulses++;
        chk("l0_rd", b_rd, 32'hCAFEF00D);
      end
      prev = b_ready;
    end
    b_mreq = 0;
    chk("l0_pulses", 32'(pulses), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
